// File: rtl/text_line_sender_pkg.sv
// Shared constants and types for the register-dump line sender: glyph codes,
// sender FSM states, per-line symbol indices and the queued entry layout.
package text_pkg;

  localparam logic [7:0] GLYPH_BLANK  = 8'd16;
  localparam logic [7:0] GLYPH_CURSOR = 8'd17;
  localparam logic [7:0] GLYPH_ERR    = 8'd18;
  localparam logic [7:0] CTRL_NEWLINE = 8'd19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RELEASE
  } sender_state_t;

  typedef logic [2:0] sym_idx_t;

  localparam sym_idx_t IDX_ADDR  = 3'd0;
  localparam sym_idx_t IDX_BLANK = 3'd1;
  localparam sym_idx_t IDX_VALUE = 3'd2;
  localparam sym_idx_t IDX_ERR   = 3'd3;
  localparam sym_idx_t IDX_NL    = 3'd4;

  typedef struct packed {
    logic       err;
    logic [7:0] addr;
    logic [7:0] value;
  } entry_t;

  // Returns {DataSymbol, Write_Symbol} for one position of a screen line.
  function automatic logic [8:0] symbol_for(sym_idx_t idx, entry_t e);
    logic [8:0] s;
    case (idx)
      IDX_ADDR:  s = {1'b1, e.addr};
      IDX_BLANK: s = {1'b0, GLYPH_BLANK};
      IDX_VALUE: s = {1'b1, e.value};
      IDX_ERR:   s = {1'b0, GLYPH_ERR};
      default:   s = {1'b0, CTRL_NEWLINE};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/text_line_sender_if.sv
// Four-phase symbol handshake toward the on-screen text controller.
interface text_line_sender_if;
  logic       Valid_Symbol;
  logic       Redy_Symbol;
  logic       DataSymbol;
  logic [7:0] Write_Symbol;

  modport master (output Valid_Symbol, output DataSymbol, output Write_Symbol, input Redy_Symbol);
  modport slave  (input Valid_Symbol, input DataSymbol, input Write_Symbol, output Redy_Symbol);
endinterface

// File: rtl/text_line_sender_symbol_fifo.sv
// Small show-ahead FIFO holding queued {err, addr, value} entries.
module symbol_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/text_line_sender.sv
// Queues register-dump entries and emits each as one screen line of symbols:
// addr, blank, value, optional error mark, newline.
module text_line_sender
  import text_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LINES  = 60
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       entry_valid,
  output logic                       entry_ready,
  input  logic [7:0]                 entry_addr,
  input  logic [7:0]                 entry_value,
  input  logic                       entry_err,
  text_line_sender_if.master         sym,
  output logic                       busy,
  output logic                       screen_full,
  output logic [6:0]                 line_count
);
  sender_state_t state_reg, state_next;
  sym_idx_t      idx_reg, idx_next, adv_idx;
  entry_t        line_reg, line_next;
  entry_t        fifo_head;
  logic          valid_reg, valid_next;
  logic [8:0]    sym_reg, sym_next;
  logic [6:0]    line_count_reg, line_count_next;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;

  assign screen_full      = (line_count_reg == 7'(MAX_LINES));
  assign entry_ready      = !fifo_full && !screen_full;
  assign fifo_push        = entry_valid && entry_ready;
  assign busy             = (state_reg != S_IDLE) || !fifo_empty;
  assign line_count       = line_count_reg;
  assign sym.Valid_Symbol = valid_reg;
  assign sym.DataSymbol   = sym_reg[8];
  assign sym.Write_Symbol = sym_reg[7:0];

  symbol_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(17)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({entry_err, entry_addr, entry_value}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      idx_reg        <= IDX_ADDR;
      line_reg       <= '0;
      valid_reg      <= 1'b0;
      sym_reg        <= '0;
      line_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      line_reg       <= line_next;
      valid_reg      <= valid_next;
      sym_reg        <= sym_next;
      line_count_reg <= line_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    line_next       = line_reg;
    valid_next      = valid_reg;
    sym_next        = sym_reg;
    line_count_next = line_count_reg;
    fifo_pop        = 1'b0;
    // The error mark only appears on lines whose entry was flagged.
    adv_idx = (idx_reg == IDX_VALUE && !line_reg.err) ? IDX_NL : idx_reg + 3'd1;

    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty && !screen_full) begin
          fifo_pop   = 1'b1;
          line_next  = fifo_head;
          idx_next   = IDX_ADDR;
          sym_next   = symbol_for(IDX_ADDR, fifo_head);
          valid_next = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (sym.Redy_Symbol) begin
          valid_next = 1'b0;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!sym.Redy_Symbol) begin
          if (idx_reg == IDX_NL) begin
            line_count_next = line_count_reg + 7'd1;
            state_next      = S_IDLE;
          end else begin
            idx_next   = adv_idx;
            sym_next   = symbol_for(adv_idx, line_reg);
            valid_next = 1'b1;
            state_next = S_SEND;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_line_sender.sv
// Scoreboard bench: dut 0 uses default parameters, dut 1 has MAX_LINES = 2.
module tb_text_line_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] e_valid = '0;
  logic [1:0] e_err   = '0;
  logic [7:0] e_addr [2];
  logic [7:0] e_val  [2];
  logic [1:0] e_ready, busy_w, sfull_w;
  logic [6:0] lc [2];

  logic [1:0] v, ds;
  logic [7:0] ws [2];
  logic       redy [2];
  logic       stall [2];
  int         ack_delay [2];

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];   // {dut, DataSymbol, Write_Symbol}

  text_line_sender_if bus_a ();
  text_line_sender_if bus_b ();

  assign v[0] = bus_a.Valid_Symbol;
  assign ds[0] = bus_a.DataSymbol;
  assign ws[0] = bus_a.Write_Symbol;
  assign bus_a.Redy_Symbol = redy[0];
  assign v[1] = bus_b.Valid_Symbol;
  assign ds[1] = bus_b.DataSymbol;
  assign ws[1] = bus_b.Write_Symbol;
  assign bus_b.Redy_Symbol = redy[1];

  text_line_sender dut_a (
    .clk (clk), .rst (rst),
    .entry_valid (e_valid[0]), .entry_ready (e_ready[0]),
    .entry_addr (e_addr[0]), .entry_value (e_val[0]), .entry_err (e_err[0]),
    .sym (bus_a.master),
    .busy (busy_w[0]), .screen_full (sfull_w[0]), .line_count (lc[0])
  );

  text_line_sender #(.FIFO_DEPTH(4), .MAX_LINES(2)) dut_b (
    .clk (clk), .rst (rst),
    .entry_valid (e_valid[1]), .entry_ready (e_ready[1]),
    .entry_addr (e_addr[1]), .entry_value (e_val[1]), .entry_err (e_err[1]),
    .sym (bus_b.master),
    .busy (busy_w[1]), .screen_full (sfull_w[1]), .line_count (lc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic expect_line(input int d, input logic [7:0] a, input logic [7:0] val, input logic er);
    exp_q.push_back({1'(d), 1'b1, a});
    exp_q.push_back({1'(d), 1'b0, 8'd16});
    exp_q.push_back({1'(d), 1'b1, val});
    if (er) exp_q.push_back({1'(d), 1'b0, 8'd18});
    exp_q.push_back({1'(d), 1'b0, 8'd19});
  endtask

  task automatic push_entry(input int d, input logic [7:0] a, input logic [7:0] val,
                            input logic er, input logic acc, input logic sent);
    @(negedge clk);
    e_valid[d] = 1'b1;
    e_addr[d]  = a;
    e_val[d]   = val;
    e_err[d]   = er;
    chk($sformatf("dut%0d entry_ready addr=%02h", d, a), 32'(e_ready[d]), 32'(acc));
    if (acc && sent) expect_line(d, a, val, er);
    @(posedge clk);
    #1 e_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_w[d] || exp_q.size() != 0) && n < 3000);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s timeout: busy=%0b pending=%0d, expected idle", name, busy_w[d], exp_q.size());
    end
  endtask

  task automatic wait_valid(input int d, input string name);
    int n = 0;
    while (!v[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(v[d]), 32'd1);
  endtask

  // Receiver model plus monitor: checks hold stability and pops the scoreboard
  // on the cycle it acknowledges a symbol.
  initial begin : monitor
    logic       in_sym [2];
    logic [8:0] held [2];
    logic [8:0] cur;
    logic [9:0] expv;
    int         cnt [2];
    for (int d = 0; d < 2; d++) begin
      redy[d] = 1'b0; in_sym[d] = 1'b0; held[d] = '0; cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cur = {ds[d], ws[d]};
        if (rst || !v[d]) begin
          in_sym[d] = 1'b0;
        end else if (!in_sym[d]) begin
          in_sym[d] = 1'b1;
          held[d]   = cur;
        end else begin
          checks++;
          if (cur !== held[d]) begin
            errors++;
            $display("FAIL dut%0d hold: got %03h, expected %03h", d, cur, held[d]);
          end
        end
        if (rst) begin
          redy[d] = 1'b0;
          cnt[d]  = 0;
        end else if (!redy[d]) begin
          if (v[d] && !stall[d]) begin
            if (cnt[d] >= ack_delay[d]) begin
              redy[d] = 1'b1;
              cnt[d]  = 0;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dut%0d symbol: got %0b/%02h, expected none", d, cur[8], cur[7:0]);
              end else begin
                expv = exp_q.pop_front();
                if (expv !== {1'(d), cur}) begin
                  errors++;
                  $display("FAIL dut%0d symbol: got %0d:%0b/%02h, expected %0d:%0b/%02h",
                           d, d, cur[8], cur[7:0], expv[9], expv[8], expv[7:0]);
                end else begin
                  $display("ok   dut%0d symbol %0b/%02h", d, cur[8], cur[7:0]);
                end
              end
            end else begin
              cnt[d]++;
            end
          end
        end else if (!v[d]) begin
          redy[d] = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    stall[0] = 1'b0; stall[1] = 1'b0;
    ack_delay[0] = 3; ack_delay[1] = 0;
    e_addr[0] = '0; e_addr[1] = '0; e_val[0] = '0; e_val[1] = '0;

    repeat (3) @(negedge clk);
    chk("reset valid", 32'(v[0]), 32'd0);
    chk("reset datasymbol", 32'(ds[0]), 32'd0);
    chk("reset write_symbol", 32'(ws[0]), 32'd0);
    chk("reset line_count", 32'(lc[0]), 32'd0);
    chk("reset screen_full", 32'(sfull_w[0]), 32'd0);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset entry_ready", 32'(e_ready[0]), 32'd1);
    #1 rst = 1'b0;

    // Single entry, with first-symbol latency.
    push_entry(0, 8'h12, 8'hAB, 1'b0, 1'b1, 1'b1);
    chk("latency edge N valid", 32'(v[0]), 32'd0);
    @(posedge clk);
    #1 chk("latency edge N+1 valid", 32'(v[0]), 32'd1);
    wait_idle(0, "single");
    chk("single line_count", 32'(lc[0]), 32'd1);
    chk("single busy", 32'(busy_w[0]), 32'd0);

    // Error entry.
    push_entry(0, 8'h3A, 8'h00, 1'b1, 1'b1, 1'b1);
    wait_idle(0, "err");
    chk("err line_count", 32'(lc[0]), 32'd2);

    // Backpressure: receiver withholds its acknowledge for 20 cycles.
    stall[0] = 1'b1;
    push_entry(0, 8'h55, 8'hC3, 1'b0, 1'b1, 1'b1);
    wait_valid(0, "bp valid raised");
    repeat (20) @(negedge clk);
    chk("bp valid held", 32'(v[0]), 32'd1);
    chk("bp datasymbol held", 32'(ds[0]), 32'd1);
    chk("bp write_symbol held", 32'(ws[0]), 32'h55);
    stall[0] = 1'b0;
    wait_idle(0, "bp");
    chk("bp line_count", 32'(lc[0]), 32'd3);

    // FIFO full: six back-to-back entries while stalled; the sixth is refused.
    stall[0] = 1'b1;
    for (int i = 0; i < 6; i++)
      push_entry(0, 8'h40 + 8'(i), 8'hF0 + 8'(i), (i == 2), (i < 5), (i < 5));
    chk("fifo full entry_ready", 32'(e_ready[0]), 32'd0);
    stall[0] = 1'b0;
    wait_idle(0, "fifo full");
    chk("fifo full line_count", 32'(lc[0]), 32'd8);

    // Screen full on the MAX_LINES = 2 instance.
    push_entry(1, 8'hA1, 8'h11, 1'b0, 1'b1, 1'b1);
    push_entry(1, 8'hA2, 8'h22, 1'b1, 1'b1, 1'b1);
    push_entry(1, 8'hA3, 8'h33, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 3000 && lc[1] != 7'd2; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("sf line_count", 32'(lc[1]), 32'd2);
    chk("sf screen_full", 32'(sfull_w[1]), 32'd1);
    chk("sf entry_ready", 32'(e_ready[1]), 32'd0);
    chk("sf busy (entry queued)", 32'(busy_w[1]), 32'd1);
    chk("sf valid idle", 32'(v[1]), 32'd0);
    chk("sf all lines sent", 32'(exp_q.size()), 32'd0);
    push_entry(1, 8'hA4, 8'h44, 1'b0, 1'b0, 1'b0);

    // Reset while a symbol is being offered.
    stall[0] = 1'b1;
    push_entry(0, 8'h66, 8'h77, 1'b0, 1'b1, 1'b1);
    wait_valid(0, "rst valid raised");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst valid async", 32'(v[0]), 32'd0);
    chk("rst write_symbol", 32'(ws[0]), 32'd0);
    chk("rst line_count", 32'(lc[0]), 32'd0);
    chk("rst busy", 32'(busy_w[0]), 32'd0);
    chk("rst dut1 screen_full", 32'(sfull_w[1]), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    stall[0] = 1'b0;
    push_entry(0, 8'h7E, 8'h99, 1'b1, 1'b1, 1'b1);
    wait_idle(0, "after reset");
    chk("after reset line_count", 32'(lc[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_line_sender.md
# text_line_sender

Symbol-stream transmitter that drives the on-screen text controller's symbol input (`Valid_Symbol` / `Redy_Symbol` / `DataSymbol` / `Write_Symbol`). It queues register-dump entries and emits each one as a screen line:

- an 8-bit address as two hex digits,
- a blank,
- an 8-bit value as two hex digits,
- an optional error mark,
- a newline control.

It sits between the camera-configuration logic (SCCB register writer and readback) and the text controller. It lets configuration results be displayed without manual symbol sequencing.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entry queue depth; must be a power of 2, minimum 2.
- `MAX_LINES`, default 60: number of screen rows (6000 cells / 100 columns); no lines are sent beyond this.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, **asynchronous, active-high**.
- `entry_valid`  in  1: producer offers an entry.
- `entry_ready`  out  1: equals `!fifo_full && !screen_full`; an entry is accepted on a cycle where `entry_valid && entry_ready`.
- `entry_addr`  in  8: register address.
- `entry_value`  in  8: register value.
- `entry_err`  in  1: appends the error glyph to the line.
- `DataSymbol`  out  1: 1 means `Write_Symbol` is a byte that the receiver splits into two hex-digit glyphs (high nibble first); 0 means a raw glyph or control code.
- `Valid_Symbol`  out  1: symbol offered.
- `Write_Symbol`  out  8: symbol payload.
- `Redy_Symbol`  in  1: receiver acknowledge.
- `busy`  out  1: FSM not in `S_IDLE`, or FIFO non-empty.
- `screen_full`  out  1: sticky; set when `line_count == MAX_LINES`.
- `line_count`  out  7: number of completed lines.

## Operation
- Each line is the following symbol sequence (`DataSymbol`, `Write_Symbol`):
  1. (1, `addr`)
  2. (0, 16 = blank)
  3. (1, `value`)
  4. (0, 18 = error mark), emitted only if `err` is set
  5. (0, 19 = newline)
- Each line is therefore 4 or 5 symbols.
- Handshake, four-phase, per symbol:
  1. Raise `Valid_Symbol` with `DataSymbol` and `Write_Symbol` stable.
  2. Hold all three until `Redy_Symbol` is sampled high.
  3. Drop `Valid_Symbol`.
  4. Wait until `Redy_Symbol` is sampled low before offering the next symbol.
- `DataSymbol` and `Write_Symbol` must not change while `Valid_Symbol` is high.
- FSM states:
  - `S_IDLE`: if the FIFO is non-empty and `!screen_full`, pop the head into the line registers, set symbol index 0, raise `Valid_Symbol`, and go to `S_SEND`.
  - `S_SEND`: on `Redy_Symbol` = 1, drop `Valid_Symbol` and go to `S_RELEASE`.
  - `S_RELEASE`: on `Redy_Symbol` = 0:
    - if symbols remain, advance the index (skipping the error-mark symbol when `err` = 0), load the next symbol, raise `Valid_Symbol`, and go to `S_SEND`;
    - otherwise increment `line_count` and go to `S_IDLE`.
- Screen full:
  - When `line_count` reaches `MAX_LINES`, `screen_full` goes to 1 and stays set until `rst`.
  - Queued entries remain in the FIFO and are not sent.
  - `entry_ready` = 0.
- FIFO:
  - Push and pop in the same cycle are allowed, including when the FIFO is full (the count is unchanged).
  - Pushes are ignored while `entry_ready` = 0.

## Timing
- Reset values: `Valid_Symbol` 0, `DataSymbol` 0, `Write_Symbol` 0, `line_count` 0, `screen_full` 0, `busy` 0, FIFO empty, FSM in `S_IDLE`.
  - After reset, `entry_ready` = 1.
- Latency, entry to first symbol: an entry accepted into an empty FIFO at edge N is popped at edge N+1. `Valid_Symbol` is high from edge N+1.
- `Valid_Symbol` falls on the edge after `Redy_Symbol` is first sampled high.
- The next `Valid_Symbol` rises on the edge after `Redy_Symbol` is first sampled low.
  - Minimum symbol period: 2 cycles plus receiver latency.
- `line_count` increments on the edge that exits `S_RELEASE` after the newline symbol.
  - `screen_full` is a combinational compare of the registered `line_count`.
- Reset mid-handshake: all outputs return to reset values asynchronously and queued entries are lost. The receiver shares `rst`, so both ends restart together.
- `Redy_Symbol` high in `S_IDLE` is ignored.

## Structure
- Package `text_pkg`:
  - constants `GLYPH_BLANK = 8'd16`, `GLYPH_CURSOR = 8'd17`, `GLYPH_ERR = 8'd18`, `CTRL_NEWLINE = 8'd19`;
  - state enum `sender_state_t` (`S_IDLE`, `S_SEND`, `S_RELEASE`);
  - a 3-bit symbol-index type.
- Sub-module `symbol_fifo`:
  - synchronous FIFO, 17 bits wide (`{err, addr, value}`), `FIFO_DEPTH` entries;
  - registered count; `full` and `empty` flags;
  - asynchronous reset.

## Test plan
- Single entry: addr 0x12, value 0xAB, err 0; a receiver model acks after 3 cycles → symbols (1,0x12), (0,16), (1,0xAB), (0,19); `line_count` 0→1; `busy` returns to 0.
- Error entry: addr 0x3A, value 0x00, err 1 → (1,0x3A), (0,16), (1,0x00), (0,18), (0,19).
- Backpressure: `Redy_Symbol` withheld for 20 cycles → `Valid_Symbol`, `DataSymbol` and `Write_Symbol` held constant throughout; exactly one symbol is consumed per handshake.
- FIFO full: 6 back-to-back entries with the receiver stalled → first entry popped, next 4 queued, `entry_ready` = 0 for the sixth. Releasing the receiver → 5 lines are sent in order.
- Screen full: `MAX_LINES` = 2, 3 entries → 2 lines sent; `screen_full` = 1; third entry stays queued; `entry_ready` = 0.
- Reset during `S_SEND` → `Valid_Symbol` drops immediately; after release, a new entry is sent correctly starting from `line_count` 0.
